// File: rtl/integrate_dump.sv
// Symbol-rate integrate-and-dump for the MPSK demodulator: sums SPS signed I/Q
// samples per symbol, realigns to an external symbol strobe, flags misaligned strobes.
module integrate_dump #(
    parameter int IN_WIDTH  = 16,
    parameter int SPS       = 8,
    parameter int CNT_W     = $clog2(SPS),
    parameter int OUT_WIDTH = IN_WIDTH + CNT_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        sample_valid,
    input  logic signed [IN_WIDTH-1:0]  i_in,
    input  logic signed [IN_WIDTH-1:0]  q_in,
    input  logic                        sym_sync,
    output logic signed [OUT_WIDTH-1:0] i_sum,
    output logic signed [OUT_WIDTH-1:0] q_sum,
    output logic                        dump_valid,
    output logic                        resync,
    output logic [15:0]                 sym_cnt,
    output logic                        dbg_state
);

    if (SPS < 2 || SPS > 256) begin : g_bad_sps
        $error("integrate_dump: SPS must be in 2..256");
    end
    if (OUT_WIDTH < IN_WIDTH + $clog2(SPS)) begin : g_bad_width
        $error("integrate_dump: OUT_WIDTH too narrow for SPS samples");
    end

    typedef enum logic {
        S_WAIT_SYNC = 1'b0,
        S_ACCUM     = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);

    state_t                      r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic signed [OUT_WIDTH-1:0] r_acc_i, r_acc_q, w_acc_i_nxt, w_acc_q_nxt;
    logic signed [OUT_WIDTH-1:0] r_i_sum, r_q_sum, w_i_sum_nxt, w_q_sum_nxt;
    logic                        r_dump, r_resync, w_dump_nxt, w_resync_nxt;
    logic [15:0]                 r_sym_cnt, w_sym_cnt_nxt;
    logic signed [OUT_WIDTH-1:0] w_xi, w_xq;

    assign w_xi = {{(OUT_WIDTH-IN_WIDTH){i_in[IN_WIDTH-1]}}, i_in};
    assign w_xq = {{(OUT_WIDTH-IN_WIDTH){q_in[IN_WIDTH-1]}}, q_in};

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_i_nxt   = r_acc_i;
        w_acc_q_nxt   = r_acc_q;
        w_i_sum_nxt   = r_i_sum;
        w_q_sum_nxt   = r_q_sum;
        w_dump_nxt    = 1'b0;
        w_resync_nxt  = 1'b0;
        w_sym_cnt_nxt = r_sym_cnt;

        unique case (r_state)
            S_WAIT_SYNC: begin
                if (sample_valid && sym_sync) begin
                    w_acc_i_nxt = w_xi;
                    w_acc_q_nxt = w_xq;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sample_valid) begin
                    // A strobe mid-symbol wins even over the completing sample.
                    if (sym_sync && r_cnt != '0) begin
                        w_acc_i_nxt  = w_xi;
                        w_acc_q_nxt  = w_xq;
                        w_cnt_nxt    = CNT_W'(1);
                        w_resync_nxt = 1'b1;
                    end else if (r_cnt == LAST_CNT) begin
                        w_i_sum_nxt   = r_acc_i + w_xi;
                        w_q_sum_nxt   = r_acc_q + w_xq;
                        w_dump_nxt    = 1'b1;
                        w_sym_cnt_nxt = r_sym_cnt + 16'd1;
                        w_acc_i_nxt   = '0;
                        w_acc_q_nxt   = '0;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_acc_i_nxt = r_acc_i + w_xi;
                        w_acc_q_nxt = r_acc_q + w_xq;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_WAIT_SYNC;
            r_cnt     <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_i_sum   <= '0;
            r_q_sum   <= '0;
            r_dump    <= 1'b0;
            r_resync  <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc_i   <= w_acc_i_nxt;
            r_acc_q   <= w_acc_q_nxt;
            r_i_sum   <= w_i_sum_nxt;
            r_q_sum   <= w_q_sum_nxt;
            r_dump    <= w_dump_nxt;
            r_resync  <= w_resync_nxt;
            r_sym_cnt <= w_sym_cnt_nxt;
        end
    end

    assign i_sum      = r_i_sum;
    assign q_sum      = r_q_sum;
    assign dump_valid = r_dump;
    assign resync     = r_resync;
    assign sym_cnt    = r_sym_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_integrate_dump.sv
// Directed table-driven bench for integrate_dump at SPS=4, IN_WIDTH=8 (10-bit sums).
module tb_integrate_dump;

    localparam int IW = 8;
    localparam int NS = 4;
    localparam int OW = 10;

    logic                 clk;
    logic                 rstn;
    logic                 sample_valid;
    logic signed [IW-1:0] i_in, q_in;
    logic                 sym_sync;
    logic signed [OW-1:0] i_sum, q_sum;
    logic                 dump_valid, resync;
    logic [15:0]          sym_cnt;
    logic                 dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    integrate_dump #(.IN_WIDTH(IW), .SPS(NS)) dut (
        .clk(clk), .rstn(rstn), .sample_valid(sample_valid),
        .i_in(i_in), .q_in(q_in), .sym_sync(sym_sync),
        .i_sum(i_sum), .q_sum(q_sum), .dump_valid(dump_valid),
        .resync(resync), .sym_cnt(sym_cnt), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 v;
        logic                 s;
        logic signed [IW-1:0] i;
        logic signed [IW-1:0] q;
        logic                 ed;
        logic                 er;
        logic signed [OW-1:0] ei;
        logic signed [OW-1:0] eq;
        logic [15:0]          ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic s, int i, int q, logic ed, logic er,
                                int ei, int eq, int ec);
        vec_t r;
        r.v = v; r.s = s; r.i = IW'(i); r.q = IW'(q);
        r.ed = ed; r.er = er; r.ei = OW'(ei); r.eq = OW'(eq); r.ec = 16'(ec);
        vecs.push_back(r);
    endfunction

    task automatic chk(string name, int row, logic signed [31:0] act, logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, int row, logic ed, logic er, int ei, int eq, int ec);
        chk({tag, ".dump_valid"}, row, 32'(dump_valid), 32'(ed));
        chk({tag, ".resync"},     row, 32'(resync),     32'(er));
        chk({tag, ".i_sum"},      row, 32'(i_sum),      32'(ei));
        chk({tag, ".q_sum"},      row, 32'(q_sum),      32'(eq));
        chk({tag, ".sym_cnt"},    row, 32'(sym_cnt),    32'(ec));
    endtask

    task automatic drive(logic v, logic s, int i, int q);
        @(negedge clk);
        sample_valid = v;
        sym_sync     = s;
        i_in         = IW'(i);
        q_in         = IW'(q);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; sample_valid = 1'b0; sym_sync = 1'b0; i_in = '0; q_in = '0;
        #1;
        chk_outs("reset", 0, 1'b0, 1'b0, 0, 0, 0);
        chk("reset.state", 0, 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // No sync after reset: everything ignored
        for (int k = 0; k < 20; k++) add(1, 0, 7 + k, -3, 0, 0, 0, 0, 0);
        // Aligned symbol: I=1..4, Q=-1 each
        add(1, 1, 1, -1, 0, 0, 0, 0, 0);
        add(1, 0, 2, -1, 0, 0, 0, 0, 0);
        add(1, 0, 3, -1, 0, 0, 0, 0, 0);
        add(1, 0, 4, -1, 1, 0, 10, -4, 1);
        // Gapped repeat, aligned sync at cnt==0, sync on an invalid cycle ignored
        add(1, 1, 1, -1, 0, 0, 10, -4, 1);
        add(0, 0, 99, 99, 0, 0, 10, -4, 1);
        add(0, 1, 55, 55, 0, 0, 10, -4, 1);
        add(1, 0, 2, -1, 0, 0, 10, -4, 1);
        add(0, 0, 0, 0, 0, 0, 10, -4, 1);
        add(0, 0, 0, 0, 0, 0, 10, -4, 1);
        add(1, 0, 3, -1, 0, 0, 10, -4, 1);
        add(0, 0, 0, 0, 0, 0, 10, -4, 1);
        add(1, 0, 4, -1, 1, 0, 10, -4, 2);
        add(0, 0, 0, 0, 0, 0, 10, -4, 2);
        // Extremes
        for (int k = 0; k < 3; k++) add(1, 0, -128, 127, 0, 0, 10, -4, 2);
        add(1, 0, -128, 127, 1, 0, -512, 508, 3);
        // Misaligned sync on 3rd sample
        add(1, 0, 5, 1, 0, 0, -512, 508, 3);
        add(1, 0, 6, 2, 0, 0, -512, 508, 3);
        add(1, 1, 10, -10, 0, 1, -512, 508, 3);
        add(1, 0, 20, -20, 0, 0, -512, 508, 3);
        add(1, 0, 30, -30, 0, 0, -512, 508, 3);
        add(1, 0, 40, -40, 1, 0, 100, -100, 4);
        // Sync on the would-be completing sample wins over the dump
        for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 0, 0, 100, -100, 4);
        add(1, 1, 2, 2, 0, 1, 100, -100, 4);
        for (int k = 0; k < 2; k++) add(1, 0, 1, 1, 0, 0, 100, -100, 4);
        add(1, 0, 1, 1, 1, 0, 5, 5, 5);

        foreach (vecs[r]) begin
            drive(vecs[r].v, vecs[r].s, int'(vecs[r].i), int'(vecs[r].q));
            chk_outs("tbl", r, vecs[r].ed, vecs[r].er, int'(vecs[r].ei),
                     int'(vecs[r].eq), int'(vecs[r].ec));
        end

        // Reset asserted mid-symbol clears outputs immediately, no partial dump
        drive(1, 1, 3, 3);
        drive(1, 0, 4, 4);
        chk_outs("pre_rst", 0, 1'b0, 1'b0, 5, 5, 5);
        @(negedge clk);
        sample_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_outs("mid_rst", 0, 1'b0, 1'b0, 0, 0, 0);
        chk("mid_rst.state", 0, 32'(dbg_state), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 9, 9);
            chk_outs("post_rst_nosync", k, 1'b0, 1'b0, 0, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, (k == 0), 2, -2);
            if (k < 3) chk_outs("post_rst_sym", k, 1'b0, 1'b0, 0, 0, 0);
            else       chk_outs("post_rst_sym", k, 1'b1, 1'b0, 8, -8, 1);
        end
        drive(0, 0, 0, 0);
        chk_outs("post_rst_idle", 0, 1'b0, 1'b0, 8, -8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/integrate_dump.md
Name: integrate_dump

Overview:
- Symbol-rate integrate-and-dump stage for the MPSK coherent demodulator.
- Sits directly upstream of the enable-gated output register. Its `dump_valid` drives that register's `en`, and `i_sum`/`q_sum` drive its `d`.
- Accumulates `SPS` signed baseband I/Q samples per symbol and emits one registered sum pair per symbol.
- Resynchronises to an external symbol strobe and flags misaligned strobes.

Parameters:
- `IN_WIDTH`, 16: signed width of `i_in`/`q_in`.
- `SPS`, 8: samples per symbol. Legal range 2..256.
- `CNT_W`, `$clog2(SPS)`: sample-counter width.
- `OUT_WIDTH`, `IN_WIDTH+CNT_W`: signed width of the sums. Elaboration error if less than `IN_WIDTH+$clog2(SPS)`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `sample_valid`  in  1  qualifies `i_in`/`q_in`/`sym_sync` this cycle.
- `i_in`  in  `IN_WIDTH`  signed in-phase sample.
- `q_in`  in  `IN_WIDTH`  signed quadrature sample.
- `sym_sync`  in  1  marks the current valid sample as first of a symbol. Ignored when `sample_valid`=0.
- `i_sum`  out  `OUT_WIDTH`  signed I sum of the last completed symbol.
- `q_sum`  out  `OUT_WIDTH`  signed Q sum of the last completed symbol.
- `dump_valid`  out  1  one-cycle pulse: `i_sum`/`q_sum` updated this cycle.
- `resync`  out  1  one-cycle pulse: `sym_sync` arrived mid-symbol and the partial sum was discarded.
- `sym_cnt`  out  16  completed-symbol counter, wraps 0xFFFF->0.

Behaviour:
- Reset (async, `rstn`=0):
  - state=WAIT_SYNC, `cnt`=0, `acc_i`=`acc_q`=0.
  - `i_sum`=`q_sum`=0, `dump_valid`=0, `resync`=0, `sym_cnt`=0.
- All outputs are registered. `dump_valid` and `resync` default to 0 every cycle.
- Inputs are sign-extended to `OUT_WIDTH` before addition. No saturation is required; the width rule guarantees no overflow.
- State WAIT_SYNC:
  - Samples are ignored.
  - On `sample_valid`&`sym_sync`: `acc`<=sign-ext(x), `cnt`<=1, go to ACCUM. If `SPS`... is always >=2, so no dump occurs on entry.
- State ACCUM, on a cycle with `sample_valid`=1:
  - `sym_sync`=1 and `cnt`!=0: discard partial; `acc`<=x, `cnt`<=1, `resync`<=1, no dump. This also applies when `cnt`==`SPS`-1: sync wins over completion.
  - `sym_sync`=1 and `cnt`==0: normal aligned boundary, no `resync`; treat as the case below.
  - `cnt`==`SPS`-1 and no misaligned sync:
    - `i_sum`<=`acc_i`+x_i, `q_sum`<=`acc_q`+x_q.
    - `dump_valid`<=1, `sym_cnt`<=`sym_cnt`+1.
    - `acc`<=0, `cnt`<=0.
  - Otherwise: `acc`<=`acc`+x, `cnt`<=`cnt`+1.
- `sample_valid`=0: `acc`, `cnt` and state hold; gaps of any length are allowed.
- Latency: `dump_valid` is high in the cycle after the edge that samples the SPS-th valid sample.
  - Back-to-back symbols with continuous `sample_valid` give one `dump_valid` pulse every `SPS` cycles.
- `i_sum`/`q_sum` hold their last value between dumps. The downstream register zeroes its output when `dump_valid`=0.
- Reset asserted mid-symbol: all state clears immediately. After release, the block waits for `sym_sync` again; no partial dump.
- `dump_valid` and `resync` are never both 1 in the same cycle.

Test Plan:
1. Reset then continuous valid, `SPS`=4, `IN_WIDTH`=8. `sym_sync` on the first sample; I = 1,2,3,4, Q = -1,-1,-1,-1 -> one `dump_valid` pulse, `i_sum`=10, `q_sum`=-4, `sym_cnt`=1, 1 cycle after the 4th sample.
2. Extremes, `SPS`=4: I=-128 ×4, Q=127 ×4 -> `i_sum`=-512, `q_sum`=508 (10-bit), no wrap.
3. Gapped input: `sample_valid` toggling 1,0,0,1,... -> same sums as scenario 1; `dump_valid` only after the 4th valid sample.
4. Misaligned sync: `sym_sync` on the 3rd sample of a symbol -> `resync` pulse, no `dump_valid`. The next dump sums exactly 4 samples starting at the sync sample.
5. No sync after reset: 20 valid samples with `sym_sync`=0 -> no `dump_valid`, sums stay 0. A subsequent sync plus 4 samples -> normal dump.
6. `rstn` pulsed low after 2 samples of a symbol -> all outputs 0 immediately, no dump, `sym_cnt`=0. Accumulation resumes only after the next `sym_sync`.
